booth_r4_seq_mult: RTL and testbench
====================================

Name: booth_r4_seq_mult

Overview:
Parametrised sequential radix-4 (modified Booth) multiplier. It contains both the controller and the datapath.
- Successor to the radix-2 multiplier controller: generic width, signed/unsigned mode, one Booth digit per cycle, registered product.
- Sits between the operand source and the result consumer. Uses the same START / end_mult level handshake.

Parameters:
- N, default 8, operand width. Must be even and >= 4; elaboration error otherwise.
- ITER, derived = N/2+1, number of Booth iterations (multiplier extended to N+2 bits).
- CW, derived = $clog2(ITER+1), iteration counter width.

Ports:
- CLK  input  1  clock, rising edge.
- RESET  input  1  reset, synchronous, active-low.
- START  input  1  request level; held high until end_mult is seen.
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with the operands.
- A  input  N  multiplicand, sampled on the accepting edge.
- B  input  N  multiplier, sampled on the accepting edge.
- P  output  2N  product, registered.
- busy  output  1  high while iterating.
- end_mult  output  1  product valid, held until START drops.

Behaviour:
- Reset (RESET==0 at a rising edge) has priority over all else: state=IDLE, P=0, busy=0, end_mult=0, counter=0, internal registers=0.
- Reset mid-RUN or in DONE abandons the operation; no end_mult is produced for it.
- States (shared enum): IDLE, RUN, DONE.
- IDLE:
  - START==1 at an edge -> capture operands into the internal registers:
    - M = A extended to N+2 bits (sign-extend if signed_mode, else zero-extend).
    - Q = B extended to N+2 bits, same rule, with an appended q[-1]=0.
    - acc = 0, counter = 0.
  - Go to RUN. P keeps its old value.
- RUN, one Booth digit per cycle:
  - Decode {q1,q0,q-1}: 000/111 -> 0; 001/010 -> +M; 011 -> +2M; 100 -> -2M; 101/110 -> -M.
  - Add the decoded value to acc at width N+3.
  - Arithmetic shift {acc,Q} right by 2; counter++.
  - After ITER RUN cycles: P <= low 2N bits of {acc,Q} (the result is exact mod 2^2N in both modes); go to DONE.
  - START and operand changes during RUN are ignored.
- DONE:
  - end_mult=1; P stable.
  - START==0 -> IDLE (end_mult drops the cycle after).
  - START==1 -> stay in DONE.
- busy=1 exactly in RUN.
- end_mult=1 exactly in DONE.
- P holds its value through IDLE until the next DONE entry overwrites it.
- Latency: START sampled at edge t0 -> end_mult and P valid after edge t0+ITER (N=8: 5 edges). Throughput is one product per ITER+2 cycles minimum.
- Back-to-back: START stays high through DONE -> no restart. START must be seen low for at least one edge before a new request.
- Boundary operands must be correct: most-negative * most-negative (signed), all-ones * all-ones (unsigned), and zero in either operand.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package booth_pkg:
  - state_e {IDLE,RUN,DONE}.
  - booth_op_e {OP_ZERO,OP_PM,OP_P2M,OP_NM,OP_N2M}.
  - Function booth_decode(3-bit) -> booth_op_e.
- Sub-module booth_r4_pp_gen:
  - Combinational; parametrised by N.
  - Takes M and the 3-bit digit; produces the N+3-bit signed addend.
  - Instantiated once.
- FSM, counter and shift registers stay in the top module.

Test Plan:
1. N=8, signed_mode=1, A=0x80, B=0x80, START held -> end_mult rises 5 edges after acceptance, P=0x4000; drop START -> IDLE next edge, end_mult=0.
2. N=8, signed_mode=0, A=0xFF, B=0xFF -> P=0xFE01. The same operands with signed_mode=1 -> P=0x0001. A=0xFF, B=0x01 signed -> P=0xFFFF.
3. Handshake: START held 10 cycles after end_mult -> stays in DONE with P stable, busy=0. Toggle A/B during RUN -> result unaffected. A=0x00, B=0x7F -> P=0.
4. Reset mid-RUN (RESET=0 on the 3rd RUN cycle) -> next cycle state=IDLE, P=0, busy=0, end_mult=0. A fresh request then completes correctly (A=3, B=-5 signed -> P=0xFFF1).
5. N=16, 2000 random operands in both modes, compared against a reference model. Also check busy high for exactly 9 cycles per operation and end_mult only in DONE.

Source files
------------

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared states, Booth digit encoding and decoder
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  typedef enum logic [2:0] {
    OP_ZERO,
    OP_PM,
    OP_P2M,
    OP_NM,
    OP_N2M
  } booth_op_e;

  // Digit is {q1, q0, q-1} of the current multiplier window.
  function automatic booth_op_e booth_decode(input logic [2:0] digit);
    booth_op_e op;
    op = OP_ZERO;
    case (digit)
      3'b001, 3'b010: op = OP_PM;
      3'b011:         op = OP_P2M;
      3'b100:         op = OP_N2M;
      3'b101, 3'b110: op = OP_NM;
      default:        op = OP_ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_r4_seq_mult_if.sv
// rtl/booth_r4_seq_mult_if.sv - operand request / product handshake bundle
interface booth_r4_seq_mult_if #(
  parameter int N = 8
);

  logic           START;
  logic           signed_mode;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic [2*N-1:0] P;
  logic           busy;
  logic           end_mult;

  modport master (
    output START, signed_mode, A, B,
    input  P, busy, end_mult
  );

  modport slave (
    input  START, signed_mode, A, B,
    output P, busy, end_mult
  );

endinterface

// File: rtl/booth_r4_pp_gen.sv
// rtl/booth_r4_pp_gen.sv - radix-4 Booth partial product (0, +-M, +-2M)
module booth_r4_pp_gen
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N+1:0] m,
  input  logic [2:0]   digit,
  output logic [N+2:0] addend
);

  logic [N+2:0] m1;
  logic [N+2:0] m2;

  assign m1 = {m[N+1], m};
  assign m2 = {m, 1'b0};

  always_comb begin
    addend = '0;
    case (booth_decode(digit))
      OP_PM:   addend = m1;
      OP_P2M:  addend = m2;
      OP_NM:   addend = -m1;
      OP_N2M:  addend = -m2;
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// rtl/booth_r4_seq_mult.sv - sequential radix-4 Booth multiplier, one digit per cycle
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int N = 8
) (
  input  logic              CLK,
  input  logic              RESET,
  booth_r4_seq_mult_if.slave bus
);

  localparam int ITER = N / 2 + 1;
  localparam int CW   = $clog2(ITER + 1);

  if (((N % 2) != 0) || (N < 4)) begin : g_bad_n
    $error("booth_r4_seq_mult: N must be even and >= 4");
  end

  state_e         state;
  state_e         state_nxt;
  logic [N+1:0]   m_reg;
  logic [N+2:0]   q_reg;
  logic [N+2:0]   acc;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] p_reg;
  logic           busy_reg;
  logic           end_reg;
  logic [N+2:0]   addend;
  logic [N+2:0]   sum;
  logic           last;
  logic           ext_a;
  logic           ext_b;

  booth_r4_pp_gen #(.N(N)) u_pp_gen (
    .m      (m_reg),
    .digit  (q_reg[2:0]),
    .addend (addend)
  );

  assign sum   = acc + addend;
  assign last  = (cnt == CW'(ITER - 1));
  assign ext_a = bus.signed_mode & bus.A[N-1];
  assign ext_b = bus.signed_mode & bus.B[N-1];

  assign bus.P        = p_reg;
  assign bus.busy     = busy_reg;
  assign bus.end_mult = end_reg;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.START) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (!bus.START) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // q_reg[0] is q[-1]; after the final shift the product starts at q bit 1,
  // so its low 2N bits are sum[N-1:0] above the surviving q_reg[N+2:3].
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      m_reg    <= '0;
      q_reg    <= '0;
      acc      <= '0;
      cnt      <= '0;
      p_reg    <= '0;
      busy_reg <= 1'b0;
      end_reg  <= 1'b0;
    end else begin
      busy_reg <= (state_nxt == RUN);
      end_reg  <= (state_nxt == DONE);
      case (state)
        IDLE: begin
          if (bus.START) begin
            m_reg <= {{2{ext_a}}, bus.A};
            q_reg <= {{2{ext_b}}, bus.B, 1'b0};
            acc   <= '0;
            cnt   <= '0;
          end
        end
        RUN: begin
          acc   <= {{2{sum[N+2]}}, sum[N+2:2]};
          q_reg <= {sum[1:0], q_reg[N+2:2]};
          cnt   <= cnt + CW'(1);
          if (last) begin
            p_reg <= {sum[N-1:0], q_reg[N+2:3]};
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_r4_seq_mult.sv
// tb/tb_booth_r4_seq_mult.sv - scoreboard bench for the radix-4 Booth multiplier
module tb_booth_r4_seq_mult;

  logic CLK = 1'b0;
  logic RESET;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] exp_q[$];

  always #5 CLK = ~CLK;

  booth_r4_seq_mult_if #(.N(8))  bus8 ();
  booth_r4_seq_mult_if #(.N(16)) bus16 ();

  booth_r4_seq_mult #(.N(8)) dut8 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus8.slave)
  );

  booth_r4_seq_mult #(.N(16)) dut16 (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus16.slave)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [31:0] ref_prod(input int n, input logic [15:0] a,
                                           input logic [15:0] b, input logic sm);
    longint sa, sb, pr, mask;
    sa = longint'(a);
    sb = longint'(b);
    if (sm && a[n-1]) sa = sa - (64'sd1 <<< n);
    if (sm && b[n-1]) sb = sb - (64'sd1 <<< n);
    pr   = sa * sb;
    mask = (64'sd1 <<< (2 * n)) - 1;
    return 32'(pr & mask);
  endfunction

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input bit scramble, output int lat, output int busy_n);
    bus8.A = a;
    bus8.B = b;
    bus8.signed_mode = sm;
    bus8.START = 1'b1;
    exp_q.push_back(ref_prod(8, {8'h0, a}, {8'h0, b}, sm));
    tick();
    lat = 0;
    busy_n = 0;
    while (bus8.end_mult !== 1'b1 && lat < 40) begin
      if (bus8.busy === 1'b1) busy_n++;
      if (scramble) begin
        bus8.A = 8'($urandom);
        bus8.B = 8'($urandom);
        bus8.signed_mode = 1'($urandom);
      end
      tick();
      lat++;
    end
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                       output int lat, output int busy_n);
    bus16.A = a;
    bus16.B = b;
    bus16.signed_mode = sm;
    bus16.START = 1'b1;
    exp_q.push_back(ref_prod(16, a, b, sm));
    tick();
    lat = 0;
    busy_n = 0;
    while (bus16.end_mult !== 1'b1 && lat < 40) begin
      if (bus16.busy === 1'b1) busy_n++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    RESET = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus8.P !== 16'h0 || bus8.busy !== 1'b0 || bus8.end_mult !== 1'b0) begin
      n_bad++;
      $display("FAIL reset8 got P=%h busy=%b end=%b want P=0000 busy=0 end=0",
               bus8.P, bus8.busy, bus8.end_mult);
    end
    n_cmp++;
    if (bus16.P !== 32'h0 || bus16.busy !== 1'b0 || bus16.end_mult !== 1'b0) begin
      n_bad++;
      $display("FAIL reset16 got P=%h busy=%b end=%b want 0/0/0",
               bus16.P, bus16.busy, bus16.end_mult);
    end
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_signed_corner();
    int lat, bn;
    logic [31:0] e;
    run8(8'h80, 8'h80, 1'b1, 1'b0, lat, bn);
    n_cmp++;
    if (lat !== 5) begin
      n_bad++;
      $display("FAIL corner_latency got %0d want 5", lat);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if ({16'h0, bus8.P} !== e) begin
      n_bad++;
      $display("FAIL corner_product got %h want %h", bus8.P, e);
    end
    bus8.START = 1'b0;
    tick();
    n_cmp++;
    if (bus8.end_mult !== 1'b0 || bus8.busy !== 1'b0 || {16'h0, bus8.P} !== e) begin
      n_bad++;
      $display("FAIL corner_release got end=%b busy=%b P=%h want 0/0/%h",
               bus8.end_mult, bus8.busy, bus8.P, e);
    end
  endtask

  task automatic test_modes();
    logic [7:0] ta[3] = '{8'hFF, 8'hFF, 8'hFF};
    logic [7:0] tb[3] = '{8'hFF, 8'hFF, 8'h01};
    logic       ts[3] = '{1'b0, 1'b1, 1'b1};
    int lat, bn;
    logic [31:0] e;
    for (int i = 0; i < 3; i++) begin
      run8(ta[i], tb[i], ts[i], 1'b0, lat, bn);
      e = exp_q.pop_front();
      n_cmp++;
      if (lat !== 5 || {16'h0, bus8.P} !== e) begin
        n_bad++;
        $display("FAIL mode_%0d got lat=%0d P=%h want lat=5 P=%h", i, lat, bus8.P, e);
      end
      bus8.START = 1'b0;
      tick();
    end
  endtask

  task automatic test_handshake();
    int lat, bn;
    logic [31:0] e;
    run8(8'h5A, 8'hC3, 1'b1, 1'b1, lat, bn);
    e = exp_q.pop_front();
    n_cmp++;
    if ({16'h0, bus8.P} !== e) begin
      n_bad++;
      $display("FAIL scramble_product got %h want %h", bus8.P, e);
    end
    n_cmp++;
    if (bn !== 5) begin
      n_bad++;
      $display("FAIL busy8_cycles got %0d want 5", bn);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (bus8.end_mult !== 1'b1 || bus8.busy !== 1'b0 || {16'h0, bus8.P} !== e) begin
        n_bad++;
        $display("FAIL hold_%0d got end=%b busy=%b P=%h want 1/0/%h",
                 i, bus8.end_mult, bus8.busy, bus8.P, e);
      end
    end
    bus8.START = 1'b0;
    tick();
    run8(8'h00, 8'h7F, 1'b1, 1'b0, lat, bn);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== 5 || {16'h0, bus8.P} !== e) begin
      n_bad++;
      $display("FAIL zero_operand got lat=%0d P=%h want lat=5 P=%h", lat, bus8.P, e);
    end
    bus8.START = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_run();
    int lat, bn;
    bit stray;
    logic [31:0] e;
    bus8.A = 8'h05;
    bus8.B = 8'h07;
    bus8.signed_mode = 1'b1;
    bus8.START = 1'b1;
    tick();
    tick();
    tick();
    n_cmp++;
    if (bus8.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_abort_busy got %b want 1", bus8.busy);
    end
    RESET = 1'b0;
    tick();
    n_cmp++;
    if (bus8.busy !== 1'b0 || bus8.end_mult !== 1'b0 || bus8.P !== 16'h0) begin
      n_bad++;
      $display("FAIL abort got busy=%b end=%b P=%h want 0/0/0000",
               bus8.busy, bus8.end_mult, bus8.P);
    end
    RESET = 1'b1;
    bus8.START = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus8.end_mult !== 1'b0 || bus8.busy !== 1'b0) stray = 1'b1;
    end
    n_cmp++;
    if (stray) begin
      n_bad++;
      $display("FAIL abort_quiet got activity after abort want none");
    end
    run8(8'h03, 8'hFB, 1'b1, 1'b0, lat, bn);
    e = exp_q.pop_front();
    n_cmp++;
    if (lat !== 5 || {16'h0, bus8.P} !== e) begin
      n_bad++;
      $display("FAIL after_abort got lat=%0d P=%h want lat=5 P=%h", lat, bus8.P, e);
    end
    bus8.START = 1'b0;
    tick();
  endtask

  task automatic test_random16();
    int lat, bn;
    logic [31:0] e;
    logic [15:0] a, b;
    logic sm;
    for (int i = 0; i < 2000; i++) begin
      a  = 16'($urandom);
      b  = 16'($urandom);
      sm = 1'(i);
      case (i)
        0, 1: begin a = 16'h8000; b = 16'h8000; end
        2, 3: begin a = 16'hFFFF; b = 16'hFFFF; end
        4:    a = 16'h0000;
        5:    b = 16'h0000;
        default: ;
      endcase
      run16(a, b, sm, lat, bn);
      n_cmp++;
      if (lat !== 9) begin
        n_bad++;
        $display("FAIL r16_latency_%0d got %0d want 9", i, lat);
      end
      n_cmp++;
      if (bn !== 9 || bus16.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL r16_busy_%0d got cycles=%0d busy_at_done=%b want 9/0",
                 i, bn, bus16.busy);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (bus16.P !== e) begin
        n_bad++;
        $display("FAIL r16_product_%0d a=%h b=%h s=%b got %h want %h",
                 i, a, b, sm, bus16.P, e);
      end
      bus16.START = 1'b0;
      tick();
      n_cmp++;
      if (bus16.end_mult !== 1'b0 || bus16.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL r16_idle_%0d got end=%b busy=%b want 0/0",
                 i, bus16.end_mult, bus16.busy);
      end
    end
  endtask

  initial begin
    bus8.START = 1'b0;
    bus8.signed_mode = 1'b0;
    bus8.A = '0;
    bus8.B = '0;
    bus16.START = 1'b0;
    bus16.signed_mode = 1'b0;
    bus16.A = '0;
    bus16.B = '0;
    RESET = 1'b0;
    test_reset();
    test_signed_corner();
    test_modes();
    test_handshake();
    test_reset_mid_run();
    test_random16();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
